// File: rtl/sev_segm_pkg.sv
// Shared constants, segment table and scan-state type for the seven-segment scan controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package sev_segm_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 15 is listed first: F, E, D, ... , 1, 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {BLANK, SHOW} scan_state_t;

  function automatic logic [6:0] hex2segm(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/sev_segm_scan_ctrl_if.sv
// User-side write port and board-side display outputs of the scan controller.
interface sev_segm_scan_ctrl_if #(parameter int N_DIGITS = 4);
  logic                    load;
  logic [4*N_DIGITS-1:0]   data_in;
  logic [N_DIGITS-1:0]     dig_en_in;
  logic                    pending;
  logic [6:0]              segm;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_start;

  modport master (
    output load, data_in, dig_en_in,
    input  pending, segm, an, frame_start
  );

  modport slave (
    input  load, data_in, dig_en_in,
    output pending, segm, an, frame_start
  );
endinterface

// File: rtl/sev_segm_scan_ctrl_seg_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg_decode
  import sev_segm_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] segm
);
  assign segm = hex2segm(nib);
endmodule

// File: rtl/sev_segm_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-boundary shadow register.
// Build option SEV_SEGM_LZ_BLANK_EN enables leading-zero blanking.
//
// state | meaning
// BLANK | cnt < BLANK_CYC, all anodes off while segments settle
// SHOW  | anode of digit idx driven low if enabled (and not a leading zero)
module sev_segm_scan_ctrl
  import sev_segm_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIV_MAX   = 49999,
  parameter int BLANK_CYC = 2,
  parameter int DIV_W     = 16
)(
  input logic clk,
  input logic rst,
  sev_segm_scan_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] CNT_BLANK = DIV_W'(BLANK_CYC);

  typedef logic [N_DIGITS-1:0][3:0] nib_arr_t;

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  nib_arr_t            disp_q, disp_d, pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0] en_q, en_d, pend_en_q, pend_en_d;
  logic [N_DIGITS-1:0] an_q, an_d, lz_mask;
  logic                pending_q, pending_d;
  logic                frame_start_q, frame_start_d;
  logic [6:0]          segm_q, segm_d;
  logic                slot_wrap, commit;
  scan_state_t         state_d;

  always_comb begin
    slot_wrap   = (cnt_q == CNT_LAST);
    commit      = slot_wrap && (idx_q == IDX_LAST);
    cnt_d       = slot_wrap ? '0 : cnt_q + DIV_W'(1);
    idx_d       = idx_q;
    if (slot_wrap)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    pending_d   = pending_q;
    disp_d      = disp_q;
    en_d        = en_q;
    if (bus.load) begin
      pend_data_d = bus.data_in;
      pend_en_d   = bus.dig_en_in;
      pending_d   = 1'b1;
    end
    // A load landing in the commit cycle is picked up here as well (bypass).
    if (commit && pending_d) begin
      disp_d    = pend_data_d;
      en_d      = pend_en_d;
      pending_d = 1'b0;
    end
    frame_start_d = commit;
  end

`ifdef SEV_SEGM_LZ_BLANK_EN
  logic zero_above;
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (disp_d[k] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    state_d = (cnt_d < CNT_BLANK) ? BLANK : SHOW;
    an_d    = '1;
    if (state_d == SHOW && en_d[idx_d] && !lz_mask[idx_d])
      an_d[idx_d] = 1'b0;
  end

  seg_decode u_seg_decode (
    .nib  (disp_d[idx_d]),
    .segm (segm_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      disp_q        <= '0;
      en_q          <= '1;
      pend_data_q   <= '0;
      pend_en_q     <= '1;
      pending_q     <= 1'b0;
      an_q          <= '1;
      segm_q        <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      en_q          <= en_d;
      pend_data_q   <= pend_data_d;
      pend_en_q     <= pend_en_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      segm_q        <= segm_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pending     = pending_q;
  assign bus.segm        = segm_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sev_segm_scan_ctrl.sv
// Self-checking bench for sev_segm_scan_ctrl: directed scenarios plus random writes/resets,
// compared every cycle against a cycle-count based reference model.
module tb_sev_segm_scan_ctrl;
  localparam int N_DIGITS  = 4;
  localparam int DIV_MAX   = 9;
  localparam int BLANK_CYC = 2;
  localparam int DIV_W     = 16;
  localparam int SLOT      = DIV_MAX + 1;
  localparam int FRAME     = N_DIGITS * SLOT;

  logic clk = 1'b0;
  logic rst;

  sev_segm_scan_ctrl_if #(.N_DIGITS(N_DIGITS)) bus ();

  sev_segm_scan_ctrl #(
    .N_DIGITS  (N_DIGITS),
    .DIV_MAX   (DIV_MAX),
    .BLANK_CYC (BLANK_CYC),
    .DIV_W     (DIV_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model: position in the scan is just cycles since reset
  int          pos;
  logic [15:0] disp_m, pend_m;
  logic [3:0]  en_m, pend_en_m;
  logic        pending_m, after_rst, valid;
  logic [6:0]  seg_ref [16];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (pos %0d)", tag, obs, exp_v, pos);
    end
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] d, input logic [3:0] e,
                            input logic r);
    if (r) begin
      pos       = 0;
      disp_m    = 16'h0;
      en_m      = 4'hF;
      pend_m    = 16'h0;
      pend_en_m = 4'hF;
      pending_m = 1'b0;
      after_rst = 1'b1;
      valid     = 1'b1;
    end else begin
      if (ld) begin
        pend_m    = d;
        pend_en_m = e;
        pending_m = 1'b1;
      end
      if ((pos % FRAME) == FRAME - 1 && pending_m) begin
        disp_m    = pend_m;
        en_m      = pend_en_m;
        pending_m = 1'b0;
      end
      pos++;
      after_rst = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int         slot_cyc, digit;
    logic [3:0] exp_an, nib;
    logic [6:0] exp_seg;
    logic       show;
    if (!valid) return;
    slot_cyc = pos % SLOT;
    digit    = (pos / SLOT) % N_DIGITS;
    nib      = 4'(disp_m >> (4 * digit));
    show     = en_m[digit];
`ifdef SEV_SEGM_LZ_BLANK_EN
    if (digit > 0 && (disp_m >> (4 * digit)) == 16'h0) show = 1'b0;
`endif
    exp_an = 4'hF;
    if (slot_cyc >= BLANK_CYC && show) exp_an[digit] = 1'b0;
    exp_seg = after_rst ? 7'h7F : seg_ref[nib];
    chk("an", bus.an, exp_an);
    chk("segm", bus.segm, exp_seg);
    chk("frame_start", bus.frame_start, (!after_rst && (pos % FRAME) == 0));
    chk("pending", bus.pending, pending_m);
  endtask

  task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] e,
                       input logic r);
    bus.load      = ld;
    bus.data_in   = d;
    bus.dig_en_in = e;
    rst           = r;
    @(posedge clk);
    model_edge(ld, d, e, r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < FRAME && (pos % FRAME) != ph; i++) idle();
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  re;
    seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    valid = 1'b0;
    pos   = 0;

    // reset then one free-running frame of zeros
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 4'hF, 1'b1);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_segm", bus.segm, 7'h7F);
    run(FRAME + 1);

    // mid-frame write, commits at frame boundary
    run_to(15);
    cycle(1'b1, 16'h12AF, 4'hF, 1'b0);
    chk("load_pending", bus.pending, 1'b1);
    run_to(0);
    chk("commit_slot0_segm", bus.segm, 7'h0E);
    run(FRAME);

    // last writer wins
    run_to(5);
    cycle(1'b1, 16'h1111, 4'hF, 1'b0);
    run_to(20);
    cycle(1'b1, 16'h2222, 4'hF, 1'b0);
    run_to(0);
    chk("overwrite_segm", bus.segm, 7'h24);
    run(SLOT);

    // load exactly in the commit cycle goes straight to the display
    run_to(FRAME - 1);
    cycle(1'b1, 16'h3333, 4'hF, 1'b0);
    chk("bypass_segm", bus.segm, 7'h30);
    chk("bypass_pending", bus.pending, 1'b0);
    run(FRAME);

    // disabled digits 1 and 3
    run_to(10);
    cycle(1'b1, 16'h5555, 4'b0101, 1'b0);
    run_to(0);
    run(2 * FRAME);

    // reset mid-slot drops a pending write
    run_to(22);
    cycle(1'b1, 16'h4321, 4'hF, 1'b0);
    run_to(25);
    cycle(1'b0, 16'h0, 4'hF, 1'b1);
    chk("midrst_an", bus.an, 4'hF);
    chk("midrst_segm", bus.segm, 7'h7F);
    chk("midrst_pending", bus.pending, 1'b0);
    run(FRAME + 5);

    // leading-zero patterns
    run_to(3);
    cycle(1'b1, 16'h0070, 4'hF, 1'b0);
    run_to(0);
    run(FRAME);
    cycle(1'b1, 16'h0000, 4'hF, 1'b0);
    run_to(0);
    run(FRAME);

    // random writes, enables and occasional resets
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
      re = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      cycle(($urandom_range(0, 9) == 0), rd, re, ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sev_segm_scan_ctrl.md
Name: sev_segm_scan_ctrl

Overview:
- Time-multiplexes one hex-to-seven-segment decoder across N_DIGITS common-anode digits, giving each digit one refresh slot per frame.
- Sits between the user logic (counters, button capture) and the board's segment and anode pins.
- Holds a shadow register so user writes appear only at a frame boundary; no tearing.
- Blanks all anodes briefly at every digit switch to suppress ghosting.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- DIV_MAX, 49999, slot length minus 1 in clk cycles; 50 MHz gives 1 kHz per digit.
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYC <= DIV_MAX.
- DIV_W, 16, width of the slot counter; must satisfy 2**DIV_W > DIV_MAX.

Ports:
- clk  in  1  system clock; only clock in the block.
- rst  in  1  synchronous reset, active-high.
- load  in  1  single-cycle write strobe.
- data_in  in  4*N_DIGITS  hex nibbles; nibble k is digit k; digit 0 is rightmost.
- dig_en_in  in  N_DIGITS  per-digit enable, captured together with data_in.
- pending  out  1  high while a written value waits for the frame boundary.
- segm  out  7  active-low segments {g,f,e,d,c,b,a}.
- an  out  N_DIGITS  active-low digit anodes.
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0.

Behaviour:
- Reset values (synchronous): idx=0, cnt=0, disp=0, en_reg=all ones, pend_data=0, pending=0, an=all ones, segm=7'h7F, frame_start=0.
- Slot counter cnt counts 0..DIV_MAX, then wraps to 0 and advances idx, modulo N_DIGITS.
- State per slot:
  - BLANK while cnt < BLANK_CYC: an=all ones.
  - SHOW otherwise: an[idx]=0 if en_reg[idx], else all ones.
- Slot length is DIV_MAX+1 cycles. Frame length is N_DIGITS*(DIV_MAX+1) cycles.
- segm = decode(disp[idx]) from registered disp and idx; it changes only on slot-boundary edges, during BLANK.
- Encoding: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E (hex, active-low). No other codes are possible.
- Write rule: load=1 captures data_in and dig_en_in into pend_data/pend_en and sets pending=1.
  - A later load while pending=1 overwrites; last writer wins; no error.
- Commit edge: the edge where idx goes N_DIGITS-1 to 0 with cnt wrapping. If pending=1, disp<=pend_data, en_reg<=pend_en, pending<=0.
  - Slot 0 of the new frame shows the new value.
- load in the commit cycle: the new data_in commits directly (bypass) and pending ends 0.
- frame_start=1 for the first cycle after the commit edge.
- Reset mid-slot: an goes all ones on the next edge and the scan restarts from digit 0; a pending write is lost.
- Disabled digits keep their anode high for the whole slot; timing of the other digits is unchanged.

Optional Feature:
- Macro: SEV_SEGM_LZ_BLANK_EN.
- Defined: leading-zero blanking. At SHOW, digit k is suppressed (an[k]=1) when k>0 and every nibble of disp from k up to N_DIGITS-1 is 0. Digit 0 is always shown if enabled, so value 0 displays "0". Applied on top of en_reg.
- Undefined: all enabled digits are shown, including leading zeros.

Decomposition:
- Package sev_segm_pkg holds:
  - SEG_BLANK=7'h7F;
  - the 16-entry segment constant table and function hex2segm(logic [3:0]);
  - enum scan_state_t {BLANK, SHOW}.
- One sub-module, seg_decode: a purely combinational nibble-to-segm wrapper over hex2segm, instantiated once. The controller owns all sequencing.

Test Plan (bench settings: DIV_MAX=9, BLANK_CYC=2, N_DIGITS=4):
- Reset for 3 cycles, then run 40 cycles: an=4'b1111 for cycles 0-1 of each slot, then 1110, 1101, 1011, 0111 in order; segm=7'h40 throughout; frame_start high at cycles 0 and 40.
- load data_in=16'h12AF, dig_en_in=4'hF at mid-frame: pending=1 until the commit edge, then segm sequence is 0E, 08, 24, 79 for slots 0..3.
- Two loads (16'h1111, then 16'h2222) within one frame: only 2222 is displayed and pending clears at commit. A load exactly in the commit cycle with 16'h3333: slot 0 shows 7'h30 and pending=0.
- dig_en_in=4'b0101: an never asserts digits 1 or 3 and slot timing is unchanged (frame still 40 cycles).
- Assert rst for 1 cycle at cnt=5 of slot 2: next cycle an=1111 and segm=7'h7F, scan restarts at idx 0, and the pending write is discarded.
- With SEV_SEGM_LZ_BLANK_EN, data 16'h0070: digits 3 and 2 stay dark, digit 1 shows 7'h78, digit 0 shows 7'h40. With data 0, only digit 0 lights.
